// File: rtl/adder_cla4b_pkg.sv
// adder_pkg: shared constants for the registered carry-lookahead adder.
//   CLA_GROUP     - bits handled by one lookahead group
//   OP_ADD/OP_SUB - encodings of the SEL operation select
//   DEFAULT_WIDTH - default operand/result width
package adder_pkg;
  localparam int   CLA_GROUP     = 4;
  localparam logic OP_ADD        = 1'b0;
  localparam logic OP_SUB        = 1'b1;
  localparam int   DEFAULT_WIDTH = 4;
endpackage

// File: rtl/adder_cla4b_if.sv
// adder_cla4b_if: operand/result bundle of the registered adder.
//   a, b  - operands (WIDTH bits)
//   SEL   - 0 = add, 1 = subtract
//   Sum   - registered result (WIDTH bits)
//   Cout  - registered carry out (no-borrow flag when subtracting)
//   Ovf   - registered two's complement overflow
// master drives operands and reads results; slave is the adder side.
interface adder_cla4b_if
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             SEL;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;

  modport master (output a, b, SEL, input Sum, Cout, Ovf);
  modport slave  (input a, b, SEL, output Sum, Cout, Ovf);
endinterface

// File: rtl/adder_cla4b_cla4.sv
// cla4_block: one 4-bit carry-lookahead group (purely combinational).
//   p, g   - per-bit propagate / generate
//   cin    - carry into bit 0 of the group
//   sum    - sum bits, sum[i] = p[i] ^ c[i]
//   c      - carries c[1..4] (c[4] is the group carry out)
//   grp_g  - group generate, grp_p - group propagate
module cla4_block
  import adder_pkg::*;
(
  input  logic [CLA_GROUP-1:0] p,
  input  logic [CLA_GROUP-1:0] g,
  input  logic                 cin,
  output logic [CLA_GROUP-1:0] sum,
  output logic [CLA_GROUP:1]   c,
  output logic                 grp_g,
  output logic                 grp_p
);
  // Each carry is a flat sum-of-products of g/p/cin, so no carry waits on
  // another carry inside the group.
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);
  assign grp_p = &p;

  assign sum = p ^ {c[3:1], cin};
endmodule

// File: rtl/adder_cla4b.sv
// adder_cla4b: registered carry-lookahead adder/subtractor.
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, clears all outputs
//   bus  - slave side of adder_cla4b_if (a, b, SEL in; Sum, Cout, Ovf out)
// Subtraction is a + ~b + 1; the result and flags are registered, giving
// one cycle of latency and a new result every cycle.
module adder_cla4b
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
)(
  input  logic          clk,
  input  logic          rst,
  adder_cla4b_if.slave  bus
);
  localparam int NG = WIDTH / CLA_GROUP;

  if ((WIDTH < CLA_GROUP) || (WIDTH % CLA_GROUP != 0)) begin : g_width_check
    $error("adder_cla4b: WIDTH must be a positive multiple of 4");
  end

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] s;
  logic [WIDTH:1]   carry;
  logic [NG:0]      grp_c;
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;
  logic             cin;

  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             ovf_reg;

  assign b_eff    = (bus.SEL == OP_ADD) ? bus.b : ~bus.b;
  assign cin      = (bus.SEL == OP_SUB);
  assign p        = bus.a ^ b_eff;
  assign g        = bus.a & b_eff;
  assign grp_c[0] = cin;

  for (genvar gi = 0; gi < NG; gi++) begin : g_group
    cla4_block u_cla4 (
      .p     (p[gi*CLA_GROUP +: CLA_GROUP]),
      .g     (g[gi*CLA_GROUP +: CLA_GROUP]),
      .cin   (grp_c[gi]),
      .sum   (s[gi*CLA_GROUP +: CLA_GROUP]),
      .c     (carry[gi*CLA_GROUP+1 +: CLA_GROUP]),
      .grp_g (grp_g[gi]),
      .grp_p (grp_p[gi])
    );
    // Group carry-in comes from the previous group's G/P, not from its
    // internal carry chain.
    assign grp_c[gi+1] = grp_g[gi] | (grp_p[gi] & grp_c[gi]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_reg  <= '0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      sum_reg  <= s;
      cout_reg <= grp_c[NG];
      // Signed overflow: carry into the MSB differs from carry out of it.
      ovf_reg  <= carry[WIDTH] ^ carry[WIDTH-1];
    end
  end

  assign bus.Sum  = sum_reg;
  assign bus.Cout = cout_reg;
  assign bus.Ovf  = ovf_reg;
endmodule

// File: tb/tb_adder_cla4b.sv
// tb_adder_cla4b: self-checking bench for adder_cla4b (WIDTH = 4).
// Expected values come from directed constants or from an arithmetic
// reference model (integer add/subtract and signed range test).
module tb_adder_cla4b;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  adder_cla4b_if #(.WIDTH(4)) bus ();

  adder_cla4b #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: returns {ovf, cout, sum[3:0]}.
  function automatic logic [5:0] ref_model(input int av, input int bv, input bit sub);
    int r, sa, sb, sr;
    logic [3:0] sm;
    logic co, ov;
    r  = sub ? (av - bv) : (av + bv);
    sm = r[3:0];
    co = sub ? (av >= bv) : (r > 15);
    sa = (av > 7) ? av - 16 : av;
    sb = (bv > 7) ? bv - 16 : bv;
    sr = sub ? (sa - sb) : (sa + sb);
    ov = (sr > 7) || (sr < -8);
    return {ov, co, sm};
  endfunction

  // Drive inputs at the falling edge, return just after the next rising edge.
  task automatic drive(input logic [3:0] av, input logic [3:0] bv, input logic sv, input logic rv);
    @(negedge clk);
    bus.a = av; bus.b = bv; bus.SEL = sv; rst = rv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      drive(4'd5, 4'd3, 1'b0, 1'b1);
      n_cmp++;
      if ({bus.Ovf, bus.Cout, bus.Sum} !== 6'd0) begin
        n_fail++;
        $display("FAIL reset[%0d]: got ovf=%b cout=%b sum=%0d, want 0/0/0", i, bus.Ovf, bus.Cout, bus.Sum);
      end
      $display("reset cycle %0d: sum=%0d cout=%b ovf=%b", i, bus.Sum, bus.Cout, bus.Ovf);
    end
    drive(4'd1, 4'd0, 1'b0, 1'b0);
    n_cmp++;
    if ({bus.Ovf, bus.Cout, bus.Sum} !== {1'b0, 1'b0, 4'd1}) begin
      n_fail++;
      $display("FAIL reset_release: got ovf=%b cout=%b sum=%0d, want 0/0/1", bus.Ovf, bus.Cout, bus.Sum);
    end
    $display("after release 1+0: sum=%0d cout=%b ovf=%b", bus.Sum, bus.Cout, bus.Ovf);
  endtask

  task automatic test_add;
    logic [3:0] ta [4] = '{4'd4, 4'd3, 4'd7, 4'd8};
    logic [3:0] tb [4] = '{4'd6, 4'd11, 4'd8, 4'd8};
    logic [5:0] te [4] = '{{1'b1, 1'b0, 4'd10}, {1'b0, 1'b0, 4'd14},
                           {1'b0, 1'b0, 4'd15}, {1'b1, 1'b1, 4'd0}};
    for (int i = 0; i < 4; i++) begin
      drive(ta[i], tb[i], 1'b0, 1'b0);
      n_cmp++;
      if ({bus.Ovf, bus.Cout, bus.Sum} !== te[i]) begin
        n_fail++;
        $display("FAIL add %0d+%0d: got ovf=%b cout=%b sum=%0d, want ovf=%b cout=%b sum=%0d",
                 ta[i], tb[i], bus.Ovf, bus.Cout, bus.Sum, te[i][5], te[i][4], te[i][3:0]);
      end
      $display("add %0d+%0d: sum=%0d cout=%b ovf=%b", ta[i], tb[i], bus.Sum, bus.Cout, bus.Ovf);
    end
    drive(4'd15, 4'd15, 1'b0, 1'b0);
    n_cmp++;
    if ({bus.Cout, bus.Sum} !== {1'b1, 4'd14}) begin
      n_fail++;
      $display("FAIL add 15+15: got cout=%b sum=%0d, want cout=1 sum=14", bus.Cout, bus.Sum);
    end
    $display("add 15+15: sum=%0d cout=%b ovf=%b", bus.Sum, bus.Cout, bus.Ovf);
  endtask

  task automatic test_sub;
    logic [3:0] ta [4] = '{4'd1, 4'd15, 4'd0, 4'd8};
    logic [3:0] tb [4] = '{4'd1, 4'd15, 4'd1, 4'd1};
    logic [5:0] te [4] = '{{1'b0, 1'b1, 4'd0}, {1'b0, 1'b1, 4'd0},
                           {1'b0, 1'b0, 4'd15}, {1'b1, 1'b1, 4'd7}};
    for (int i = 0; i < 4; i++) begin
      drive(ta[i], tb[i], 1'b1, 1'b0);
      n_cmp++;
      if ({bus.Ovf, bus.Cout, bus.Sum} !== te[i]) begin
        n_fail++;
        $display("FAIL sub %0d-%0d: got ovf=%b cout=%b sum=%0d, want ovf=%b cout=%b sum=%0d",
                 ta[i], tb[i], bus.Ovf, bus.Cout, bus.Sum, te[i][5], te[i][4], te[i][3:0]);
      end
      $display("sub %0d-%0d: sum=%0d cout=%b ovf=%b", ta[i], tb[i], bus.Sum, bus.Cout, bus.Ovf);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] av, bv;
    logic       sv, rv;
    logic [5:0] exp;
    for (int i = 0; i < 40; i++) begin
      av = 4'($urandom_range(15));
      bv = 4'($urandom_range(15));
      sv = 1'($urandom_range(1));
      rv = (i == 20);
      exp = rv ? 6'd0 : ref_model(int'(av), int'(bv), sv);
      drive(av, bv, sv, rv);
      n_cmp++;
      if ({bus.Ovf, bus.Cout, bus.Sum} !== exp) begin
        n_fail++;
        $display("FAIL b2b[%0d] a=%0d b=%0d sel=%b rst=%b: got %b_%b_%0d, want %b_%b_%0d",
                 i, av, bv, sv, rv, bus.Ovf, bus.Cout, bus.Sum, exp[5], exp[4], exp[3:0]);
      end
      $display("b2b[%0d] a=%0d b=%0d sel=%b rst=%b: sum=%0d cout=%b ovf=%b",
               i, av, bv, sv, rv, bus.Sum, bus.Cout, bus.Ovf);
    end
  endtask

  task automatic test_exhaustive;
    logic [5:0] exp;
    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          exp = ref_model(x, y, s[0]);
          drive(4'(x), 4'(y), s[0], 1'b0);
          n_cmp++;
          if ({bus.Ovf, bus.Cout, bus.Sum} !== exp) begin
            n_fail++;
            $display("FAIL exh a=%0d b=%0d sel=%0d: got %b_%b_%0d, want %b_%b_%0d",
                     x, y, s, bus.Ovf, bus.Cout, bus.Sum, exp[5], exp[4], exp[3:0]);
          end
          $display("exh a=%0d b=%0d sel=%0d: sum=%0d cout=%b ovf=%b",
                   x, y, s, bus.Sum, bus.Cout, bus.Ovf);
        end
      end
    end
  endtask

  task automatic test_glitch;
    logic [3:0] av, bv;
    logic       sv;
    logic [5:0] held, exp;
    for (int i = 0; i < 8; i++) begin
      av = 4'($urandom_range(15));
      bv = 4'($urandom_range(15));
      sv = 1'($urandom_range(1));
      drive(av, bv, sv, 1'b0);
      held = ref_model(int'(av), int'(bv), sv);
      // Now 1 time unit after the edge; toggle inputs until just before the next edge.
      for (int k = 0; k < 6; k++) begin
        #1;
        bus.a = 4'($urandom_range(15));
        bus.b = 4'($urandom_range(15));
        bus.SEL = 1'($urandom_range(1));
      end
      #1;
      av = bus.a; bv = bus.b; sv = bus.SEL;
      exp = ref_model(int'(av), int'(bv), sv);
      n_cmp++;
      if ({bus.Ovf, bus.Cout, bus.Sum} !== held) begin
        n_fail++;
        $display("FAIL glitch_hold[%0d]: got %b_%b_%0d, want %b_%b_%0d",
                 i, bus.Ovf, bus.Cout, bus.Sum, held[5], held[4], held[3:0]);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if ({bus.Ovf, bus.Cout, bus.Sum} !== exp) begin
        n_fail++;
        $display("FAIL glitch_edge[%0d] a=%0d b=%0d sel=%b: got %b_%b_%0d, want %b_%b_%0d",
                 i, av, bv, sv, bus.Ovf, bus.Cout, bus.Sum, exp[5], exp[4], exp[3:0]);
      end
      $display("glitch[%0d] edge a=%0d b=%0d sel=%b: sum=%0d cout=%b ovf=%b",
               i, av, bv, sv, bus.Sum, bus.Cout, bus.Ovf);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.a = 4'd0;
    bus.b = 4'd0;
    bus.SEL = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_exhaustive();
    test_glitch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
